// File: rtl/rotation_cmd_encoder.sv
// rotation_cmd_encoder: turns a (direction, magnitude) command into an ASCII
// line such as "R48\n", one byte per handshake on a valid/ready byte port.
// The magnitude is converted to BCD by a bit-serial double-dabble, and
// leading zeros are suppressed.
// Optional build macro CRLF_TERM_EN: the line terminator becomes "\r\n"
// instead of "\n".
module rotation_cmd_encoder #(
    parameter int MAG_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [MAG_W-1:0] cmd_mag,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data,
    output logic             busy,
    output logic [31:0]      line_count
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(MAG_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MAG_W - 1);

`ifdef CRLF_TERM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONV    = 3'd1,
        S_DIR     = 3'd2,
        S_DIGIT   = 3'd3,
        S_TERM_CR = 3'd4,
        S_TERM    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_DIR   = 3'd2,
        S_DIGIT = 3'd3,
        S_TERM  = 3'd5
    } state_t;
`endif

    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [MAG_W-1:0]     shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     dig_idx_q, dig_idx_d;
    logic [31:0]          line_count_q, line_count_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 byte_valid_q, byte_valid_d;
    logic [7:0]           byte_data_q, byte_data_d;

    logic                 cmd_hs;
    logic                 byte_hs;
    logic [BCD_W+MAG_W-1:0] dabble;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Index of the most significant nonzero digit; an all-zero value yields 0.
    function automatic logic [IDX_W-1:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign cmd_hs     = cmd_valid && cmd_ready_q;
    assign byte_hs    = byte_valid_q && byte_ready;
    assign cmd_ready  = cmd_ready_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign line_count = line_count_q;
    assign busy       = (state_q != S_IDLE);

    // State register plus all datapath and registered-output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            dig_idx_q    <= '0;
            line_count_q <= '0;
            cmd_ready_q  <= 1'b1;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            shift_q      <= shift_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            dig_idx_q    <= dig_idx_d;
            line_count_q <= line_count_d;
            cmd_ready_q  <= cmd_ready_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
        end
    end

    // Next-state logic: walk the line one field at a time, advancing on handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_hs) state_d = S_CONV;
            S_CONV:    if (cnt_q == LAST_BIT) state_d = S_DIR;
            S_DIR:     if (byte_hs) state_d = S_DIGIT;
`ifdef CRLF_TERM_EN
            S_DIGIT:   if (byte_hs && (dig_idx_q == '0)) state_d = S_TERM_CR;
            S_TERM_CR: if (byte_hs) state_d = S_TERM;
`else
            S_DIGIT:   if (byte_hs && (dig_idx_q == '0)) state_d = S_TERM;
`endif
            S_TERM:    if (byte_hs) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the command, run the BCD conversion, step the digit pointer, count lines.
    always_comb begin
        dir_d        = dir_q;
        shift_d      = shift_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        dig_idx_d    = dig_idx_q;
        line_count_d = line_count_q;
        dabble       = {bcd_adjust(bcd_q), shift_q} << 1;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    dir_d   = cmd_dir;
                    shift_d = cmd_mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CONV: begin
                bcd_d   = dabble[BCD_W+MAG_W-1 -: BCD_W];
                shift_d = dabble[MAG_W-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    dig_idx_d = msd_index(bcd_d);
                end
            end
            S_DIGIT: begin
                if (byte_hs && (dig_idx_q != '0)) begin
                    dig_idx_d = dig_idx_q - IDX_W'(1);
                end
            end
            S_TERM: begin
                if (byte_hs) begin
                    line_count_d = line_count_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs are decoded from the state being entered, so they line up with it.
    always_comb begin
        cmd_ready_d  = 1'b0;
        byte_valid_d = 1'b0;
        byte_data_d  = 8'h00;
        case (state_d)
            S_IDLE: cmd_ready_d = 1'b1;
            S_DIR: begin
                byte_valid_d = 1'b1;
                byte_data_d  = dir_q ? 8'h52 : 8'h4C;
            end
            S_DIGIT: begin
                byte_valid_d = 1'b1;
                byte_data_d  = 8'h30 + {4'h0, bcd_q[int'(dig_idx_d) * 4 +: 4]};
            end
`ifdef CRLF_TERM_EN
            S_TERM_CR: begin
                byte_valid_d = 1'b1;
                byte_data_d  = 8'h0D;
            end
`endif
            S_TERM: begin
                byte_valid_d = 1'b1;
                byte_data_d  = 8'h0A;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rotation_cmd_encoder.sv
// Testbench for rotation_cmd_encoder: table of commands with expected ASCII
// lines, a byte scoreboard, plus directed latency, queuing and reset sequences.
module tb_rotation_cmd_encoder;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [31:0] cmd_mag;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        busy;
    logic [31:0] line_count;

    rotation_cmd_encoder #(.MAG_W(32), .DIGITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_mag    (cmd_mag),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .busy       (busy),
        .line_count (line_count)
    );

    typedef struct {
        bit          dir;
        logic [31:0] mag;
        string       txt;
        bit          rnd;
    } vec_t;

    vec_t        vecs[8];
    logic [7:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          model_lines = 0;
    bit          line_open = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = 8'h00;
    int          ready_mode = 0;
`ifdef CRLF_TERM_EN
    string       term = "\r\n";
`else
    string       term = "\n";
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink readiness: 0 always ready, 1 random, 2 held low, 3 single-cycle pulse.
    initial begin
        byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: byte_ready = (($urandom & 1) == 1);
                2: byte_ready = 1'b0;
                3: begin byte_ready = 1'b1; ready_mode = 2; end
                default: byte_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard / protocol monitor.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
                line_open  = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", byte_valid, 1);
                    chk("stall_data", byte_data, prev_data);
                end
                if (line_open) chk("cmd_ready_busy", cmd_ready, 0);
                if (cmd_valid && cmd_ready) begin
                    line_open = 1;
                    n_acc++;
                end
                if (byte_valid && byte_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %02h expected none", byte_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", byte_data, e);
                        if (e == 8'h0A) begin
                            line_open = 0;
                            model_lines++;
                        end
                    end
                end
                prev_stall = byte_valid && !byte_ready;
                prev_data  = byte_data;
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send(input bit d, input logic [31:0] m, input string s, input bit add_term);
        int t;
        push_str(s);
        if (add_term) push_str(term);
        @(posedge clk);
        #1;
        cmd_dir   = d;
        cmd_mag   = m;
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 300);
        if (t >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_dir   = ~d;
        cmd_mag   = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_q.size() == 0 && !busy && !line_open) && t < 1000);
        if (t >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        int cyc;
        int acc0;
        int blen;
        vecs[0] = '{1'b0, 32'd0,          "L0",          1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF,   "L4294967295", 1'b0};
        vecs[2] = '{1'b0, 32'd100,        "L100",        1'b0};
        vecs[3] = '{1'b1, 32'd999,        "R999",        1'b1};
        vecs[4] = '{1'b1, 32'd7,          "R7",          1'b1};
        vecs[5] = '{1'b0, 32'd10,         "L10",         1'b0};
        vecs[6] = '{1'b1, 32'd1000000000, "R1000000000", 1'b1};
        vecs[7] = '{1'b0, 32'd65535,      "L65535",      1'b0};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_mag   = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_count", line_count, 0);
        #2 rst = 1'b1;

        // "R48": first byte valid 33 cycles after the accept cycle.
        ready_mode = 0;
        push_str("R48");
        push_str(term);
        @(posedge clk);
        #1;
        cmd_dir   = 1'b1;
        cmd_mag   = 32'd48;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_mag   = 32'd7777;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!byte_valid && cyc < 100);
        chk("first_byte_latency", cyc, 33);
        wait_idle("r48");
        chk("line_count_r48", line_count, 1);

        // Table-driven commands.
        for (int i = 0; i < 8; i++) begin
            ready_mode = vecs[i].rnd ? 1 : 0;
            send(vecs[i].dir, vecs[i].mag, vecs[i].txt, 1'b1);
            wait_idle(vecs[i].txt);
            chk("line_count_tbl", line_count, model_lines);
        end
        ready_mode = 0;

        // Two commands offered back to back with cmd_valid held high.
        acc0 = n_acc;
        push_str("R12");
        push_str(term);
        push_str("L34");
        push_str(term);
        blen = 3 + term.len();
        @(posedge clk);
        #1;
        cmd_dir   = 1'b1;
        cmd_mag   = 32'd12;
        cmd_valid = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!cmd_ready && cyc < 300);
        @(posedge clk);
        #1;
        cmd_dir = 1'b0;
        cmd_mag = 32'd34;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!cmd_ready && cyc < 300);
        chk("second_accept_after_term", exp_q.size(), blen);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle("queued");
        chk("two_accepts", n_acc - acc0, 2);
        chk("line_count_queued", line_count, model_lines);

        // Reset while a digit of "R1234" is stalled on the byte port.
        ready_mode = 2;
        send(1'b1, 32'd1234, "R", 1'b0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!byte_valid && cyc < 100);
        ready_mode = 3;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_digit", byte_data, 8'h31);
        #2 rst = 1'b0;
        model_lines = 0;
        @(negedge clk);
        chk("midrst_byte_valid", byte_valid, 0);
        chk("midrst_byte_data", byte_data, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_line_count", line_count, 0);
        chk("midrst_q_empty", exp_q.size(), 0);
        exp_q.delete();
        #2 rst = 1'b1;
        ready_mode = 0;
        send(1'b0, 32'd5, "L5", 1'b1);
        wait_idle("l5");
        chk("line_count_after_rst", line_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
